// File: rtl/cv32e40px_ifetch_arbiter.sv
// Round-robin arbiter that shares the single instruction-side OBI port between
// the prefetch buffer (requester 0) and a secondary fetcher (requester 1).
// An address phase that is not granted straight away is locked (HOLD) until it
// is granted. Every granted transaction's owner goes into an in-order routing
// FIFO, so each response is steered back to the requester that issued it.
module cv32e40px_ifetch_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,

  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic                       last_id_q, last_id_d;
  logic                       hold_id_q, hold_id_d;
  logic                       perr_q, perr_d;

  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PTR_W-1:0]           wptr_q, wptr_d;
  logic [PTR_W-1:0]           rptr_q, rptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                       sel_vld;
  logic                       sel_id;
  logic                       sel_req;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       grant;
  logic                       push;
  logic                       pop;
  logic                       head_id;

  assign fifo_full  = (cnt_q == CNT_MAX);
  assign fifo_empty = (cnt_q == '0);
  assign head_id    = fifo_q[rptr_q];

  // Requester selection: locked to hold_id in HOLD, round-robin on ties in ARB.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = 1'b0;
    if (state_q == HOLD) begin
      sel_vld = 1'b1;
      sel_id  = hold_id_q;
    end else if (m0_req_i && m1_req_i) begin
      sel_vld = 1'b1;
      sel_id  = ~last_id_q;
    end else if (m0_req_i) begin
      sel_vld = 1'b1;
      sel_id  = 1'b0;
    end else if (m1_req_i) begin
      sel_vld = 1'b1;
      sel_id  = 1'b1;
    end
    sel_req = sel_id ? m1_req_i : m0_req_i;
  end

  // Memory-side address phase and requester-side grant/response steering.
  // Grants are masked while rst_n is low so no requester sees a handshake
  // that the routing FIFO cannot record.
  always_comb begin
    instr_req_o    = sel_vld && sel_req && !fifo_full;
    instr_addr_o   = '0;
    if (sel_vld) begin
      instr_addr_o = sel_id ? m1_addr_i : m0_addr_i;
    end
    grant          = instr_req_o && instr_gnt_i && rst_n;
    push           = grant;
    pop            = instr_rvalid_i && !fifo_empty;

    m0_gnt_o       = grant && !sel_id;
    m1_gnt_o       = grant &&  sel_id;
    m0_rvalid_o    = pop && !head_id;
    m1_rvalid_o    = pop &&  head_id;
    m0_rdata_o     = instr_rdata_i;
    m1_rdata_o     = instr_rdata_i;
    m0_err_o       = instr_err_i && m0_rvalid_o;
    m1_err_o       = instr_err_i && m1_rvalid_o;

    busy_o         = !fifo_empty || m0_req_i || m1_req_i;
    protocol_err_o = perr_q;
  end

  // Arbiter next state: lock on an ungranted request, release on its grant.
  always_comb begin
    state_d   = state_q;
    hold_id_d = hold_id_q;
    last_id_d = last_id_q;
    unique case (state_q)
      ARB: begin
        if (instr_req_o && !instr_gnt_i) begin
          state_d   = HOLD;
          hold_id_d = sel_id;
        end
      end
      HOLD: begin
        if (grant) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (grant) begin
      last_id_d = sel_id;
    end
  end

  // Routing FIFO pointers/count; pointers wrap at MAX_OUTSTANDING, not at 2^PTR_W.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    perr_d = perr_q;
    if (push) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (instr_rvalid_i && fifo_empty) begin
      perr_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      last_id_q <= 1'b1;
      hold_id_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      hold_id_q <= hold_id_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      perr_q    <= perr_d;
    end
  end

  // Owner storage; entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= sel_id;
    end
  end

endmodule

// File: tb/tb_cv32e40px_ifetch_arbiter.sv
module tb_cv32e40px_ifetch_arbiter;

  localparam int MAXO = 2;

  logic        clk;
  logic        rst_n;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        busy_o, protocol_err_o;

  cv32e40px_ifetch_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ireq;
    logic [31:0] iaddr;
    logic        g0, g1, v0, v1, e0, e1, perr, busy;
    logic [31:0] rd0, rd1;
  } out_t;

  typedef struct {
    logic        rst;
    logic        m0r;
    logic [31:0] m0a;
    logic        m1r;
    logic [31:0] m1a;
    logic        gnt, rv;
    logic [31:0] rd;
    logic        er;
    out_t        exp;
  } vec_t;

  out_t act;
  assign act = {instr_req_o, instr_addr_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
                m0_err_o, m1_err_o, protocol_err_o, busy_o, m0_rdata_o, m1_rdata_o};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, a, e);
    end
  endtask

  function automatic vec_t V(input logic rst, input logic m0r, input logic [31:0] m0a,
                             input logic m1r, input logic [31:0] m1a, input logic gnt,
                             input logic rv, input logic [31:0] rd, input logic er,
                             input logic ireq, input logic [31:0] iaddr, input logic g0,
                             input logic g1, input logic v0, input logic v1, input logic e0,
                             input logic e1, input logic perr, input logic busy);
    vec_t v;
    v.rst = rst; v.m0r = m0r; v.m0a = m0a; v.m1r = m1r; v.m1a = m1a;
    v.gnt = gnt; v.rv = rv; v.rd = rd; v.er = er;
    v.exp = '{ireq: ireq, iaddr: iaddr, g0: g0, g1: g1, v0: v0, v1: v1, e0: e0, e1: e1,
              perr: perr, busy: busy, rd0: rd, rd1: rd};
    return v;
  endfunction

  task automatic drive(input logic m0r, input logic [31:0] m0a, input logic m1r,
                       input logic [31:0] m1a, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic er);
    m0_req_i = m0r; m0_addr_i = m0a; m1_req_i = m1r; m1_addr_i = m1a;
    instr_gnt_i = gnt; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Behavioural reference: owner queue, round-robin pointer, address-phase lock.
  int   mq[$];
  bit   m_lock, m_lock_id, m_last, m_perr;
  out_t m_exp;
  bit   m_grant, m_sel;

  task automatic model_reset();
    mq.delete();
    m_lock = 0; m_lock_id = 0; m_last = 1; m_perr = 0;
  endtask

  task automatic model_eval();
    bit ok;
    bit sreq;
    ok = 0; m_sel = 0;
    if (m_lock) begin ok = 1; m_sel = m_lock_id; end
    else if (m0_req_i && m1_req_i) begin ok = 1; m_sel = !m_last; end
    else if (m0_req_i) begin ok = 1; m_sel = 0; end
    else if (m1_req_i) begin ok = 1; m_sel = 1; end
    sreq = m_sel ? m1_req_i : m0_req_i;
    m_exp = '0;
    m_exp.ireq  = ok && sreq && (mq.size() < MAXO);
    m_exp.iaddr = ok ? (m_sel ? m1_addr_i : m0_addr_i) : 32'h0;
    m_grant     = m_exp.ireq && instr_gnt_i;
    m_exp.g0    = m_grant && !m_sel;
    m_exp.g1    = m_grant && m_sel;
    if (instr_rvalid_i && mq.size() > 0) begin
      m_exp.v0 = (mq[0] == 0);
      m_exp.v1 = (mq[0] == 1);
    end
    m_exp.e0   = m_exp.v0 && instr_err_i;
    m_exp.e1   = m_exp.v1 && instr_err_i;
    m_exp.perr = m_perr;
    m_exp.busy = (mq.size() > 0) || m0_req_i || m1_req_i;
    m_exp.rd0  = instr_rdata_i;
    m_exp.rd1  = instr_rdata_i;
  endtask

  task automatic model_update();
    if (instr_rvalid_i) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_perr = 1;
    end
    if (m_grant) begin
      mq.push_back(int'(m_sel));
      m_last = m_sel;
      m_lock = 0;
    end else if (m_exp.ireq) begin
      m_lock = 1;
      m_lock_id = m_sel;
    end
  endtask

  vec_t vecs[26];

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    //            rst m0r m0a     m1r m1a     gnt rv rd      er  ireq iaddr  g0 g1 v0 v1 e0 e1 perr busy
    vecs[0]  = V(0, 0, 0,       0, 0,       0, 0, 0,       0,  0, 0,       0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = V(0, 1, 'h100,   0, 0,       1, 0, 0,       0,  1, 'h100,   1, 0, 0, 0, 0, 0, 0, 1);
    vecs[2]  = V(0, 1, 'h104,   0, 0,       1, 1, 'hA0,    0,  1, 'h104,   1, 0, 1, 0, 0, 0, 0, 1);
    vecs[3]  = V(0, 1, 'h108,   0, 0,       1, 1, 'hA1,    0,  1, 'h108,   1, 0, 1, 0, 0, 0, 0, 1);
    vecs[4]  = V(0, 0, 0,       0, 0,       0, 1, 'hA2,    0,  0, 0,       0, 0, 1, 0, 0, 0, 0, 1);
    vecs[5]  = V(1, 1, 'h55,    0, 0,       1, 1, 'hEE,    1,  1, 'h55,    0, 0, 0, 0, 0, 0, 0, 1);
    vecs[6]  = V(0, 1, 'h300,   1, 'h400,   1, 0, 0,       0,  1, 'h300,   1, 0, 0, 0, 0, 0, 0, 1);
    vecs[7]  = V(0, 1, 'h304,   1, 'h400,   1, 0, 0,       0,  1, 'h400,   0, 1, 0, 0, 0, 0, 0, 1);
    vecs[8]  = V(0, 1, 'h304,   1, 'h404,   1, 1, 'hB0,    0,  0, 'h304,   0, 0, 1, 0, 0, 0, 0, 1);
    vecs[9]  = V(0, 1, 'h304,   1, 'h404,   1, 1, 'hB1,    1,  1, 'h304,   1, 0, 0, 1, 0, 1, 0, 1);
    vecs[10] = V(0, 0, 0,       1, 'h404,   1, 1, 'hB2,    0,  1, 'h404,   0, 1, 1, 0, 0, 0, 0, 1);
    vecs[11] = V(0, 0, 0,       0, 0,       0, 1, 'hB3,    0,  0, 0,       0, 0, 0, 1, 0, 0, 0, 1);
    vecs[12] = V(0, 0, 0,       1, 'h200,   0, 0, 0,       0,  1, 'h200,   0, 0, 0, 0, 0, 0, 0, 1);
    vecs[13] = V(0, 1, 'h500,   1, 'h200,   0, 0, 0,       0,  1, 'h200,   0, 0, 0, 0, 0, 0, 0, 1);
    vecs[14] = V(0, 1, 'h500,   1, 'h200,   0, 0, 0,       0,  1, 'h200,   0, 0, 0, 0, 0, 0, 0, 1);
    vecs[15] = V(0, 1, 'h500,   1, 'h200,   1, 0, 0,       0,  1, 'h200,   0, 1, 0, 0, 0, 0, 0, 1);
    vecs[16] = V(0, 1, 'h500,   0, 0,       1, 1, 'hC0,    0,  1, 'h500,   1, 0, 0, 1, 0, 0, 0, 1);
    vecs[17] = V(0, 0, 0,       0, 0,       0, 1, 'hC1,    1,  0, 0,       0, 0, 1, 0, 1, 0, 0, 1);
    vecs[18] = V(0, 0, 0,       0, 0,       0, 1, 'hC2,    0,  0, 0,       0, 0, 0, 0, 0, 0, 0, 0);
    vecs[19] = V(0, 0, 0,       0, 0,       0, 0, 0,       0,  0, 0,       0, 0, 0, 0, 0, 0, 1, 0);
    vecs[20] = V(0, 1, 'h600,   0, 0,       0, 0, 0,       0,  1, 'h600,   0, 0, 0, 0, 0, 0, 1, 1);
    vecs[21] = V(0, 0, 'h600,   1, 'h700,   0, 0, 0,       0,  0, 'h600,   0, 0, 0, 0, 0, 0, 1, 1);
    vecs[22] = V(0, 1, 'h600,   1, 'h700,   1, 0, 0,       0,  1, 'h600,   1, 0, 0, 0, 0, 0, 1, 1);
    vecs[23] = V(1, 0, 0,       0, 0,       0, 0, 0,       0,  0, 0,       0, 0, 0, 0, 0, 0, 0, 0);
    vecs[24] = V(0, 0, 0,       0, 0,       0, 1, 'hD0,    0,  0, 0,       0, 0, 0, 0, 0, 0, 0, 0);
    vecs[25] = V(0, 0, 0,       0, 0,       0, 0, 0,       0,  0, 0,       0, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 26; i++) begin
      rst_n = !vecs[i].rst;
      drive(vecs[i].m0r, vecs[i].m0a, vecs[i].m1r, vecs[i].m1a,
            vecs[i].gnt, vecs[i].rv, vecs[i].rd, vecs[i].er);
      #4;
      chk($sformatf("vec%0d", i), act, vecs[i].exp);
      tick();
    end
    rst_n = 1'b1;

    // Reset while locked in HOLD on m1: the lock and round-robin state clear.
    do_reset();
    drive(0, 0, 1, 'h800, 0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1, 'h900, 1, 'h800, 0, 0, 0, 0);
    #4;
    chk("hold_rst_addr", instr_addr_o, 32'h900);
    chk("hold_rst_perr", protocol_err_o, 1'b0);
    tick();

    // FIFO full: a third request is forwarded only the cycle after the first rvalid.
    do_reset();
    drive(1, 'h1000, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 'h1004, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 'h2000, 1, 0, 0, 0);
    #4;
    chk("full_block", instr_req_o, 1'b0);
    tick();
    drive(0, 0, 1, 'h2000, 1, 1, 'h11, 0);
    #4;
    chk("full_pop_block", {instr_req_o, m0_rvalid_o, m1_gnt_o}, 3'b010);
    tick();
    begin
      int n;
      bit found;
      found = 0;
      n = 0;
      drive(0, 0, 1, 'h2000, 1, 0, 0, 0);
      while (!found && n < 8) begin
        #4;
        if (m1_gnt_o) found = 1;
        else begin tick(); n++; end
      end
      chk("fwd_timeout", found, 1'b1);
      chk("fwd_latency", n, 0);
      chk("fwd_addr", instr_addr_o, 32'h2000);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 'h22, 0);
    #4;
    chk("drain0", {m0_rvalid_o, m1_rvalid_o}, 2'b10);
    tick();
    drive(0, 0, 0, 0, 0, 1, 'h33, 1);
    #4;
    chk("drain1", {m0_rvalid_o, m1_rvalid_o, m1_err_o}, 3'b011);
    tick();

    // Randomized traffic against the reference model, OBI-legal requesters.
    do_reset();
    model_reset();
    begin
      bit p0, p1;
      logic [31:0] a0, a1;
      p0 = 0; p1 = 0; a0 = 0; a1 = 0;
      for (int c = 0; c < 600; c++) begin
        if (!p0 && ($urandom % 3 == 0)) begin p0 = 1; a0 = $urandom & 32'hFFFF_FFFC; end
        if (!p1 && ($urandom % 3 == 0)) begin p1 = 1; a1 = $urandom & 32'hFFFF_FFFC; end
        drive(p0, a0, p1, a1, ($urandom % 4) != 0,
              (mq.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 40 == 0),
              $urandom, ($urandom % 5) == 0);
        model_eval();
        #4;
        chk($sformatf("rand%0d", c), act, m_exp);
        if (m_grant) begin
          if (m_sel) p1 = 0;
          else p0 = 0;
        end
        model_update();
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40px_ifetch_arbiter.md
# cv32e40px_ifetch_arbiter

Two-requester arbiter that shares the core's single instruction-side OBI port between the IF-stage prefetch buffer (requester 0) and a secondary instruction fetcher such as a debug program-buffer or trace replay unit (requester 1). It sits between those requesters and the instruction memory or cache interface (`instr_req_o` / `instr_gnt_i` / `instr_rvalid_i`).

It arbitrates address phases with round-robin fairness and holds each address phase stable until it is granted. It records the owner of every granted transaction in an in-order routing FIFO, so that each response phase returns only to the requester that issued it.

## Interface
Parameters:
- MAX_OUTSTANDING, default 2: depth of the routing FIFO, i.e. the maximum number of granted transactions still awaiting `rvalid`. Legal range is 1..4.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- m0_req_i, input, 1: requester 0 (prefetch buffer) request.
- m0_addr_i, input, 32: requester 0 word address.
- m0_gnt_o, output, 1: requester 0 grant.
- m0_rvalid_o, output, 1: requester 0 response valid.
- m0_rdata_o, output, 32: requester 0 response data.
- m0_err_o, output, 1: requester 0 bus error, qualified by `m0_rvalid_o`.
- m1_req_i, m1_addr_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o: same as requester 0, for requester 1.
- instr_req_o, output, 1: memory-side request.
- instr_addr_o, output, 32: memory-side address.
- instr_gnt_i, input, 1: memory-side grant.
- instr_rvalid_i, input, 1: memory-side response valid.
- instr_rdata_i, input, 32: memory-side response data.
- instr_err_i, input, 1: memory-side error.
- busy_o, output, 1: asserted while any transaction is outstanding or any request is pending.
- protocol_err_o, output, 1: sticky flag, set when `rvalid` arrives with no transaction outstanding.

## Operation
- Arbiter FSM has two states:
  - ARB: select a requester combinationally.
  - HOLD: locked to `hold_id`.
- ARB selection rules:
  - If only one requester asserts `req`, select it.
  - If both assert `req`, select the one that is not `last_id`.
  - `last_id` resets to 1, so requester 0 wins the first tie.
- `instr_req_o` equals the selected requester's `req`, gated by `!fifo_full`. `instr_addr_o` equals the selected requester's address. `instr_addr_o` is 0 when nothing is selected.
- ARB to HOLD: `instr_req_o` is asserted and `instr_gnt_i` is 0. Store the selected index in `hold_id`.
- In HOLD:
  - Selection is forced to `hold_id`, regardless of the other requester. This satisfies the OBI stability rule.
  - Return to ARB on the `instr_gnt_i` cycle.
- On a grant (`instr_req_o && instr_gnt_i`):
  - Assert `mX_gnt_o` for the selected requester only.
  - Push the selected index into the routing FIFO.
  - Set `last_id` to the selected index.
- Response phase:
  - `rdata` and `err` are broadcast to both requesters.
  - `mX_rvalid_o = instr_rvalid_i && !fifo_empty && head == X`.
  - Each `instr_rvalid_i` pops the FIFO head.
- FIFO implementation: circular buffer with pointer width $clog2(MAX_OUTSTANDING) (minimum 1) and a count of width $clog2(MAX_OUTSTANDING+1).
  - Pointers wrap at MAX_OUTSTANDING. They do not wrap at a power of two.
- FIFO full: no new request is forwarded. A pop in the same cycle does not unblock the push; full is evaluated on the registered count.
- Push and pop in the same cycle (not full): count is unchanged, and both pointers advance.
- `rvalid` while empty: the response is dropped, no `mX_rvalid_o` is asserted, and `protocol_err_o` is set and stays set until reset.
- Requester withdrawing `req` while in HOLD is illegal (OBI). The arbiter stays in HOLD and keeps `instr_req_o` equal to `hold_id`'s `req`.
- `busy_o = !fifo_empty || m0_req_i || m1_req_i`.

## Timing
- Zero-latency paths:
  - `req` and `addr` to `instr_req_o` / `instr_addr_o`: combinational.
  - `instr_gnt_i` to `mX_gnt_o`: combinational.
  - `instr_rvalid_i` to `mX_rvalid_o`: combinational.
- A response is accepted at the earliest in the cycle after its grant.
- Register reset values:
  - FSM state = ARB, `last_id` = 1, `hold_id` = 0.
  - FIFO count = 0, read and write pointers = 0.
  - `protocol_err_o` = 0.
- Output values during reset:
  - All `gnt`, `rvalid` and `err` outputs = 0.
  - `instr_req_o` = 0 and `instr_addr_o` = 0 when no `req` is present.
- Reset mid-transaction clears the FIFO. Responses that arrive after reset raise `protocol_err_o`; the system must reset memory together with the arbiter.
- Sustained throughput is one grant per cycle while not full and the memory grants every cycle.

## Test plan
- Single requester: m0 requests 0x100, 0x104, 0x108 back-to-back with `gnt` tied to 1 and `rvalid` one cycle later. Required response: three `m0_gnt_o` pulses, three `m0_rvalid_o` with matching data, `m1_*` silent.
- Tie after reset: both request at cycle 0 with `gnt`=1. Required grant order is m0, m1, m0, m1. Each `rvalid` routes to the issuer in order.
- HOLD lock: m1 requests 0x200 alone with `gnt`=0 for 3 cycles, and m0 raises `req` at cycle 1. Required response: `instr_addr_o` stays 0x200 through the grant, then m0 is granted on the next cycle.
- FIFO full (MAX_OUTSTANDING=2): two grants with no `rvalid`, then a third `req`. Required response: `instr_req_o`=0 until the first `rvalid`. When `rvalid` and `req` coincide, the forward occurs only in the following cycle.
- Interleaved owners: grants m0 then m1, then `rvalid` returns data A then data B with `err` on B. Required response: `m0_rvalid_o` with A, then `m1_rvalid_o` and `m1_err_o` with B.
- Spurious response: `instr_rvalid_i` with an empty FIFO. Required response: no `mX_rvalid_o`, `protocol_err_o`=1 and sticky until `rst_n` is low; reset asserted mid-burst clears the count to 0.
